vga_stream_out: RTL
===================

Name: vga_stream_out

Overview:
- Pixel-clock-domain video output stage that sits directly upstream of the HDMI/DVI serializer interface.
- Consumes a 24-bit RGB pixel stream, using a valid/ready handshake with a start-of-frame marker, from the frame-buffer reader FIFO.
- Generates VGA-style timing, producing the hsync/vsync/blank and r/g/b signals that the serializer encodes.
- Detects stream misalignment and underflow, then resynchronises on the next frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, horizontal sync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- HSYNC_POL, 0, asserted level of vga_hsync_o
- VSYNC_POL, 0, asserted level of vga_vsync_o

Ports:
- clk_pixel  in  1  pixel clock; the only clock
- reset_i  in  1  asynchronous active-high reset
- pix_data_i  in  24  pixel {r[7:0], g[7:0], b[7:0]}
- pix_sof_i  in  1  marks the first pixel of a frame
- pix_valid_i  in  1  pixel available
- pix_ready_o  out  1  pixel consumed this cycle when valid and ready are both high
- clear_status_i  in  1  clears the sticky status flags
- underflow_o  out  1  sticky flag: valid was low at an active pixel
- sync_err_o  out  1  sticky flag: sof was misplaced or missing
- frame_start_o  out  1  one-cycle pulse aligned with output pixel (0,0)
- vga_hsync_o  out  1  horizontal sync
- vga_vsync_o  out  1  vertical sync
- vga_blank_o  out  1  high outside the active area
- vga_r_o  out  8  red
- vga_g_o  out  8  green
- vga_b_o  out  8  blue

Behaviour:
- Counters:
  - H_TOTAL = sum of the four H_* parameters; V_TOTAL = sum of the four V_* parameters.
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1 to 0.
  - Counters free-run regardless of stream state.
- Decode, all combinational from the counters:
  - active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - fs = (h_cnt==0 && v_cnt==0).
- Outputs are registered with exactly 1 cycle latency from the counter values.
  - vga_hsync_o = hs ? HSYNC_POL : ~HSYNC_POL; vga_vsync_o is analogous.
  - vga_blank_o = ~active.
  - RGB = accepted pixel data, or 0 when not active, not accepted, or in SEEK.
- State machine, two states:
  - SEEK, entered after reset:
    - pix_ready_o = pix_valid_i && (~pix_sof_i || fs). Pixels without sof are dropped; a sof pixel is held until fs.
    - When fs && pix_valid_i && pix_sof_i, the pixel is consumed, displayed, and the state goes to RUN.
    - All pixels displayed in SEEK other than that one are black.
  - RUN:
    - pix_ready_o = active && pix_valid_i && ~(pix_sof_i ^ fs).
    - Active cycle with pix_valid_i=0: output black, set underflow_o, go to SEEK.
    - Active cycle with pix_sof_i != fs: do not consume, output black, set sync_err_o, go to SEEK.
- Status flags:
  - underflow_o and sync_err_o are sticky.
  - clear_status_i clears them.
  - A new error event in the same cycle as clear_status_i wins, so the flag is set.
- frame_start_o is registered fs and pulses every frame, independent of state.
- Reset values:
  - Counters 0, state SEEK.
  - Outputs: hsync and vsync at their deasserted level, blank=1, RGB=0, frame_start_o=0.
  - pix_ready_o follows the SEEK rule combinationally; status flags 0.
- Reset asserted mid-frame: everything returns to the reset values immediately (asynchronous); no pixel is consumed while reset is high.

Test Plan:
- Small timing (H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1), no stream, 2 frames:
  - H_TOTAL=8, V_TOTAL=6, so frame_start_o pulses every 48 clocks, first at cycle 1.
  - hsync is low for output h=5..6 and vsync is low for line 4.
  - blank is low for exactly 12 clocks per frame.
- Ideal stream of 12 pixels 0x000001..0x00000C with sof on the first, always valid:
  - RGB shows 0x000001..0x00000C in raster order in the second frame.
  - Flags stay 0; ready is high only for active cycles.
- Drop valid for one cycle at pixel (2,1):
  - That pixel and the rest of the frame are black; underflow_o=1; state is SEEK.
  - The next frame displays correctly after sof.
- Feed 3 junk pixels without sof before the sof frame while in SEEK:
  - The junk is dropped with ready=1, and sof is held with ready=0 until fs.
  - sync_err_o stays 0.
- Inject sof on pixel (1,0) in RUN:
  - sync_err_o=1, that pixel is not consumed, and the frame resumes at the next fs.
  - clear_status_i while an error event occurs keeps the flag at 1; a clear alone sets it to 0.
- Assert reset_i at mid-frame pixel (2,2):
  - Outputs go to their reset values asynchronously.
  - After release the counters restart at 0 and the state is SEEK.

Source files
------------

// File: rtl/vga_stream_out.sv
// VGA timing generator fed by a valid/ready RGB pixel stream with a start-of-frame marker.
// A starved or misaligned stream drops to SEEK and relocks on the next frame start.
module vga_stream_out #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clk_pixel,
    input  logic        reset_i,
    input  logic [23:0] pix_data_i,
    input  logic        pix_sof_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    input  logic        clear_status_i,
    output logic        underflow_o,
    output logic        sync_err_o,
    output logic        frame_start_o,
    output logic        vga_hsync_o,
    output logic        vga_vsync_o,
    output logic        vga_blank_o,
    output logic [7:0]  vga_r_o,
    output logic [7:0]  vga_g_o,
    output logic [7:0]  vga_b_o,
    output logic        dbg_state_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        ST_SEEK = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    logic w_active;
    logic w_hs;
    logic w_vs;
    logic w_fs;
    logic w_ready;
    logic w_show;
    logic w_uf_evt;
    logic w_se_evt;

    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank;
    logic        r_frame_start;
    logic        r_underflow;
    logic        r_sync_err;
    logic [23:0] r_rgb;

    // Raster counters free-run; the stream never stalls timing.
    always_ff @(posedge clk_pixel or posedge reset_i) begin
        if (reset_i) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign w_active = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
    assign w_hs     = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
    assign w_vs     = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
    assign w_fs     = (r_h_cnt == '0) && (r_v_cnt == '0);

    always_ff @(posedge clk_pixel or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_SEEK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SEEK: if (w_fs && pix_valid_i && pix_sof_i) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_uf_evt || w_se_evt)             w_state_nxt = ST_SEEK;
        endcase
    end

    // SEEK drains non-sof pixels and parks a sof pixel until the raster reaches (0,0).
    always_comb begin
        w_ready  = 1'b0;
        w_show   = 1'b0;
        w_uf_evt = 1'b0;
        w_se_evt = 1'b0;
        case (r_state)
            ST_SEEK: begin
                w_ready = pix_valid_i && (!pix_sof_i || w_fs);
                w_show  = w_fs && pix_valid_i && pix_sof_i;
            end
            ST_RUN: begin
                w_ready  = w_active && pix_valid_i && (pix_sof_i == w_fs);
                w_show   = w_ready;
                w_uf_evt = w_active && !pix_valid_i;
                w_se_evt = w_active && pix_valid_i && (pix_sof_i != w_fs);
            end
        endcase
    end

    assign pix_ready_o = w_ready && !reset_i;

    always_ff @(posedge clk_pixel or posedge reset_i) begin
        if (reset_i) begin
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_blank       <= 1'b1;
            r_rgb         <= 24'd0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_hsync       <= w_hs ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vs ? VSYNC_POL : ~VSYNC_POL;
            r_blank       <= ~w_active;
            r_rgb         <= w_show ? pix_data_i : 24'd0;
            r_frame_start <= w_fs;
            // A fresh event outranks a simultaneous clear.
            r_underflow   <= w_uf_evt | (r_underflow & ~clear_status_i);
            r_sync_err    <= w_se_evt | (r_sync_err & ~clear_status_i);
        end
    end

    assign vga_hsync_o   = r_hsync;
    assign vga_vsync_o   = r_vsync;
    assign vga_blank_o   = r_blank;
    assign vga_r_o       = r_rgb[23:16];
    assign vga_g_o       = r_rgb[15:8];
    assign vga_b_o       = r_rgb[7:0];
    assign frame_start_o = r_frame_start;
    assign underflow_o   = r_underflow;
    assign sync_err_o    = r_sync_err;
    assign dbg_state_o   = r_state;

endmodule
